// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage.
// A DELAY-deep complex delay line feeds back the butterfly differences.
// Twiddle multiplication is applied to those differences on the way out.
module sdf_r2_butterfly_stage #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din_r,
    input  logic [DATA_W-1:0] din_i,
    input  logic [1:0]        state,
    input  logic [DATA_W-1:0] w_r,
    input  logic [DATA_W-1:0] w_i,
    output logic [DATA_W-1:0] dout_r,
    output logic [DATA_W-1:0] dout_i,
    output logic              out_valid
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_TWID = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    // Delay line: index 0 is the head (oldest entry)
    logic signed [DATA_W-1:0] buf_r_q [DELAY];
    logic signed [DATA_W-1:0] buf_i_q [DELAY];
    logic signed [DATA_W-1:0] buf_r_d [DELAY];
    logic signed [DATA_W-1:0] buf_i_d [DELAY];

    logic signed [DATA_W-1:0] dout_r_q, dout_r_d;
    logic signed [DATA_W-1:0] dout_i_q, dout_i_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0] head_r, head_i;
    logic signed [DATA_W-1:0] din_r_s, din_i_s, w_r_s, w_i_s;
    logic signed [DATA_W-1:0] bf_sum_r, bf_sum_i, bf_dif_r, bf_dif_i;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SUM_W-1:0]  acc_r, acc_i;
    logic signed [DATA_W-1:0] tw_r, tw_i;
    logic signed [DATA_W-1:0] push_r, push_i;

    assign head_r  = buf_r_q[0];
    assign head_i  = buf_i_q[0];
    assign din_r_s = din_r;
    assign din_i_s = din_i;
    assign w_r_s   = w_r;
    assign w_i_s   = w_i;

    // Butterfly add/sub, wrapping to DATA_W bits
    assign bf_sum_r = DATA_W'(head_r + din_r_s);
    assign bf_sum_i = DATA_W'(head_i + din_i_s);
    assign bf_dif_r = DATA_W'(head_r - din_r_s);
    assign bf_dif_i = DATA_W'(head_i - din_i_s);

    // Full-precision complex multiply of the head by the twiddle, floor-scaled
    assign p_rr  = PROD_W'(head_r) * PROD_W'(w_r_s);
    assign p_ii  = PROD_W'(head_i) * PROD_W'(w_i_s);
    assign p_ri  = PROD_W'(head_r) * PROD_W'(w_i_s);
    assign p_ir  = PROD_W'(head_i) * PROD_W'(w_r_s);
    assign acc_r = SUM_W'(p_rr) - SUM_W'(p_ii);
    assign acc_i = SUM_W'(p_ri) + SUM_W'(p_ir);
    assign tw_r  = DATA_W'(acc_r >>> FRAC_W);
    assign tw_i  = DATA_W'(acc_i >>> FRAC_W);

    // Next-state: select output and feedback value by phase, then shift on valid
    always_comb begin
        buf_r_d     = buf_r_q;
        buf_i_d     = buf_i_q;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        out_valid_d = 1'b0;
        push_r      = din_r_s;
        push_i      = din_i_s;
        if (in_valid) begin
            case (state_e'(state))
                ST_BFLY: begin
                    dout_r_d    = bf_sum_r;
                    dout_i_d    = bf_sum_i;
                    push_r      = bf_dif_r;
                    push_i      = bf_dif_i;
                    out_valid_d = 1'b1;
                end
                ST_TWID: begin
                    dout_r_d    = tw_r;
                    dout_i_d    = tw_i;
                    out_valid_d = 1'b1;
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
            for (int unsigned k = 0; k + 1 < DELAY; k++) begin
                buf_r_d[k] = buf_r_q[k+1];
                buf_i_d[k] = buf_i_q[k+1];
            end
            buf_r_d[DELAY-1] = push_r;
            buf_i_d[DELAY-1] = push_i;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DELAY; k++) begin
                buf_r_q[k] <= '0;
                buf_i_q[k] <= '0;
            end
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            buf_r_q     <= buf_r_d;
            buf_i_q     <= buf_i_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Self-checking bench for sdf_r2_butterfly_stage (DELAY = 2).
// A delay-line model with plain integer arithmetic predicts every output.
module tb_sdf_r2_butterfly_stage;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned DELAY  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] din_r, din_i, w_r, w_i;
    logic [1:0]        state;
    logic [DATA_W-1:0] dout_r, dout_i;
    logic              out_valid;

    sdf_r2_butterfly_stage #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .DELAY(DELAY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .state(state),
        .w_r(w_r), .w_i(w_i),
        .dout_r(dout_r), .dout_i(dout_i), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: delay line of complex values plus expected output register
    longint mq_r[$], mq_i[$];
    longint exp_r = 0, exp_i = 0;
    bit     exp_v = 1'b0;
    longint lg_r[$], lg_i[$];

    function automatic longint wrap(input longint x);
        longint m;
        m = x & 64'hFFFFFF;
        if (m >= 64'h800000) m = m - 64'h1000000;
        return m;
    endfunction

    function automatic longint fdiv(input longint n);
        longint q;
        q = n / 256;
        if ((n % 256) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        mq_r.delete(); mq_i.delete();
        for (int k = 0; k < DELAY; k++) begin
            mq_r.push_back(0); mq_i.push_back(0);
        end
        exp_r = 0; exp_i = 0; exp_v = 1'b0;
    endtask

    // Drive one cycle of inputs and advance the model for the following edge
    task automatic send(input bit v, input int s, input longint dr, input longint di,
                        input longint wr, input longint wi);
        longint ar, ai;
        @(negedge clk);
        in_valid = v;
        state    = 2'(s);
        din_r    = dr[DATA_W-1:0];
        din_i    = di[DATA_W-1:0];
        w_r      = wr[DATA_W-1:0];
        w_i      = wi[DATA_W-1:0];
        exp_v    = 1'b0;
        if (v) begin
            ar = mq_r.pop_front();
            ai = mq_i.pop_front();
            if (s == 1) begin
                exp_r = wrap(ar + dr); exp_i = wrap(ai + di); exp_v = 1'b1;
                mq_r.push_back(wrap(ar - dr)); mq_i.push_back(wrap(ai - di));
            end else if (s == 2) begin
                exp_r = wrap(fdiv(ar * wr - ai * wi));
                exp_i = wrap(fdiv(ar * wi + ai * wr));
                exp_v = 1'b1;
                mq_r.push_back(dr); mq_i.push_back(di);
            end else begin
                mq_r.push_back(dr); mq_i.push_back(di);
            end
        end
    endtask

    task automatic idle();
        send(1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_log(input string name, input int idx, input longint er, input longint ei);
        if (idx < lg_r.size()) begin
            chk({name, "_r"}, lg_r[idx], er);
            chk({name, "_i"}, lg_i[idx], ei);
        end else begin
            chk({name, "_missing"}, lg_r.size(), idx + 1);
        end
    endtask

    // Per-cycle compare of the DUT against the model, just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (check_en) begin
                chk("out_valid", longint'(out_valid), longint'(exp_v));
                chk("dout_r", longint'($signed(dout_r)), exp_r);
                chk("dout_i", longint'($signed(dout_i)), exp_i);
                if (out_valid) begin
                    lg_r.push_back(longint'($signed(dout_r)));
                    lg_i.push_back(longint'($signed(dout_i)));
                end
            end
        end
    end

    task automatic basic_frame(input bit gaps);
        send(1, 0, 256, 0, 0, 0);    if (gaps) idle();
        send(1, 0, 512, 0, 0, 0);    if (gaps) idle();
        send(1, 1, 768, 0, 0, 0);    if (gaps) idle();
        send(1, 1, 1024, 0, 0, 0);   if (gaps) idle();
        send(1, 2, 0, 0, 256, 0);    if (gaps) idle();
        send(1, 2, 0, 0, 0, -256);
        idle();
    endtask

    longint fr_r[4][4], fr_i[4][4];
    int     valid_run;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; state = 2'd0;
        din_r = '0; din_i = '0; w_r = '0; w_i = '0;
        model_reset();
        #2;
        chk("reset_dout_r", longint'(dout_r), 0);
        chk("reset_dout_i", longint'(dout_i), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        // Basic frame
        lg_r.delete(); lg_i.delete();
        basic_frame(1'b0);
        chk_log("basic0", 0, 1024, 0);
        chk_log("basic1", 1, 1536, 0);
        chk_log("basic2", 2, -512, 0);
        chk_log("basic3", 3, 0, 512);

        // Same frame with a bubble between every input
        lg_r.delete(); lg_i.delete();
        basic_frame(1'b1);
        chk_log("stall0", 0, 1024, 0);
        chk_log("stall1", 1, 1536, 0);
        chk_log("stall2", 2, -512, 0);
        chk_log("stall3", 3, 0, 512);

        // Wrap on the butterfly sum; zero difference seen later as a twiddle input
        lg_r.delete(); lg_i.delete();
        send(1, 0, 24'h7FFFFF, 0, 0, 0);
        send(1, 0, 5, 7, 0, 0);
        send(1, 1, 24'h7FFFFF, 0, 0, 0);
        send(1, 1, 1, 1, 0, 0);
        send(1, 2, 0, 0, 256, 0);
        send(1, 2, 0, 0, 256, 0);
        idle();
        chk_log("wrap_sum", 0, -2, 0);
        chk_log("wrap_bf1", 1, 6, 8);
        chk_log("wrap_dif", 2, 0, 0);
        chk_log("wrap_dif1", 3, 4, 6);

        // Complex multiply with a negative product sum (floor rounding)
        lg_r.delete(); lg_i.delete();
        send(1, 0, -300, 100, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 2, 0, 0, 181, -181);
        send(1, 2, 0, 0, 256, 0);
        idle();
        chk_log("cmul_bf", 0, -300, 100);
        chk_log("cmul_tw", 2, -142, 282);

        // Asynchronous reset mid-stream, then a fresh fill
        send(1, 0, 40, 50, 0, 0);
        send(1, 0, 60, 70, 0, 0);
        send(1, 1, 1, 2, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        exp_v = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_dout_r", longint'(dout_r), 0);
        chk("midreset_dout_i", longint'(dout_i), 0);
        chk("midreset_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 0, 11, 12, 0, 0);
        send(1, 0, 13, 14, 0, 0);
        idle();

        // Three back-to-back frames with the N=4 DIF twiddles W0=(1,0), W1=(0,-1)
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 4; k++) begin
                fr_r[f][k] = wrap(longint'($urandom_range(0, 20000)) - 10000);
                fr_i[f][k] = wrap(longint'($urandom_range(0, 20000)) - 10000);
            end
        lg_r.delete(); lg_i.delete();
        for (int f = 0; f < 3; f++) begin
            send(1, (f == 0) ? 0 : 2, fr_r[f][0], fr_i[f][0], 256, 0);
            send(1, (f == 0) ? 0 : 2, fr_r[f][1], fr_i[f][1], 0, -256);
            send(1, 1, fr_r[f][2], fr_i[f][2], 0, 0);
            send(1, 1, fr_r[f][3], fr_i[f][3], 0, 0);
        end
        send(1, 2, fr_r[3][0], fr_i[3][0], 256, 0);
        send(1, 2, fr_r[3][1], fr_i[3][1], 0, -256);
        idle();
        chk("cont_out_count", lg_r.size(), 12);
        // Golden DIF stage: x0+x2, x1+x3, (x0-x2)*1, (x1-x3)*(-j)
        for (int f = 0; f < 3; f++) begin
            chk_log("cont_s0", 4*f + 0, wrap(fr_r[f][0] + fr_r[f][2]), wrap(fr_i[f][0] + fr_i[f][2]));
            chk_log("cont_s1", 4*f + 1, wrap(fr_r[f][1] + fr_r[f][3]), wrap(fr_i[f][1] + fr_i[f][3]));
            chk_log("cont_t0", 4*f + 2, wrap(fr_r[f][0] - fr_r[f][2]), wrap(fr_i[f][0] - fr_i[f][2]));
            chk_log("cont_t1", 4*f + 3, wrap(fr_i[f][1] - fr_i[f][3]), wrap(fr_r[f][3] - fr_r[f][1]));
        end

        // Continuous run: out_valid stays high once the first fill is done
        valid_run = 0;
        for (int f = 0; f < 2; f++) begin
            send(1, (f == 0) ? 0 : 2, 3, 4, 256, 0);
            send(1, (f == 0) ? 0 : 2, 5, 6, 0, -256);
            send(1, 1, 7, 8, 0, 0);
            send(1, 1, 9, 10, 0, 0);
        end
        send(1, 2, 0, 0, 256, 0);
        @(posedge clk); #2;
        valid_run = valid_run + int'(out_valid);
        send(1, 2, 0, 0, 0, -256);
        @(posedge clk); #2;
        valid_run = valid_run + int'(out_valid);
        chk("cont_tail_valid", valid_run, 2);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdf_r2_butterfly_stage.md
Name: sdf_r2_butterfly_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) DIF stage of the 1024-point FFT pipeline. It is the datapath that consumes the stage-control ROM's `state`, `w_r` and `w_i` outputs.
- It holds a DELAY-deep feedback shift buffer, performs the add/sub butterfly and the complex twiddle multiply, and drives one registered complex sample per valid input.
- Instances chain back to back, one per FFT stage, with DELAY = 512, 256, …, 1.

Parameters:
- DATA_W, 24, signed two's-complement width of every real/imag sample and twiddle.
- FRAC_W, 8, fractional bits of the fixed-point format (1.0 = 256).
- DELAY, 2, depth of the feedback buffer in samples (N/2 of this stage).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  din_r/din_i/state/w_r/w_i are valid this cycle.
- din_r  in  DATA_W  input sample, real part.
- din_i  in  DATA_W  input sample, imaginary part.
- state  in  2  stage phase from the control ROM: 0 = fill, 1 = butterfly, 2 = twiddle; 3 is reserved.
- w_r  in  DATA_W  twiddle, real part, Q(DATA_W−FRAC_W).FRAC_W.
- w_i  in  DATA_W  twiddle, imaginary part.
- dout_r  out  DATA_W  output sample, real part.
- dout_i  out  DATA_W  output sample, imaginary part.
- out_valid  out  1  dout_r/dout_i are valid this cycle.

Behaviour:
- Reset (async): buffer entries, dout_r, dout_i and out_valid all clear to 0. A reset mid-frame discards buffer contents and the output register immediately.
- Buffer: DELAY-entry complex shift register.
  - head = oldest entry.
  - Shifts only on in_valid = 1.
  - Each shift pushes exactly one value and pops the head.
- in_valid = 0:
  - Buffer, dout_r and dout_i hold.
  - out_valid drops to 0 on the next edge.
  - state, w_r and w_i are ignored.
- state 0 (fill), with in_valid:
  - push din.
  - out_valid <= 0.
- state 1 (butterfly), with in_valid:
  - a = head, b = din.
  - dout <= a + b (real and imag separately).
  - push a − b.
  - out_valid <= 1.
- state 2 (twiddle), with in_valid:
  - a = head.
  - dout_r <= (a_r·w_r − a_i·w_i) >>> FRAC_W.
  - dout_i <= (a_r·w_i + a_i·w_r) >>> FRAC_W.
  - push din (first half of the next frame).
  - out_valid <= 1.
- state 3, with in_valid: treated as state 0 (push din, out_valid <= 0).
- Arithmetic:
  - Products are full 2·DATA_W signed; sums use 2·DATA_W+1 bits.
  - Shift is arithmetic (floor, no rounding).
  - Results truncate to the low DATA_W bits. Add/sub likewise wraps to DATA_W bits; no saturation, no scaling.
- Latency: exactly 1 cycle from an accepted input (in_valid = 1, state 1/2) to out_valid = 1 with its result.
- Throughput: 1 sample/cycle.
- Sequence per frame: state 0 ×DELAY, state 1 ×DELAY, then state 2 ×DELAY overlapping the next frame's fill.
  - Steady state emits 2·DELAY outputs per 2·DELAY inputs.
  - Output order per frame: DELAY sums, then DELAY twiddled differences.
- Buffer is never read past empty: state sequencing guarantees a head exists in states 1/2. No full/empty flags.

Test Plan:
- Reset: assert rst_n=0 mid-stream → dout_r=dout_i=0 and out_valid=0 asynchronously; after release, the first DELAY state-0 inputs give out_valid=0.
- Basic frame (DELAY=2):
  - din_r = 256, 512, 768, 1024 (imag 0) with state 0,0,1,1 → outputs (1024,0), (1536,0), each 1 cycle after its input.
  - Next two inputs with state 2 and W = (256,0) then (0,−256, i.e. 0xFFFF00) → outputs (−512,0) then (0,512).
- Stall: insert in_valid=0 gaps between every input of the basic frame → identical output values and order; out_valid=0 in each gap cycle plus 1; dout holds.
- Wrap: a_r = b_r = 0x7FFFFF in state 1 → dout_r = 0xFFFFFE (two's-complement wrap); pushed difference = 0.
- Complex multiply: head = (−300,100), W = (181,−181) → dout_r = floor((−54300+18100)/256) = −142, dout_i = floor((54300+18100)/256) = 282.
- Continuous 3 frames with no gaps → out_valid is high every cycle after the first fill; each frame's outputs match the golden DIF stage model.
